// File: rtl/alu_seq_32.sv
// Two-pass operand sequencer for a 16-bit ALU slice: runs 16-bit ops in one pass, 32-bit ops in two.
// Optional feature macro: ALU_SEQ_CHAIN_EN adds a 'chain' input that feeds the previous c_out into the low pass.
module alu_seq_32 #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [3:0]     op,
  input  logic           mode,
  input  logic           wide,
  input  logic [2*W-1:0] a,
  input  logic [2*W-1:0] b,
  input  logic           c_in,
`ifdef ALU_SEQ_CHAIN_EN
  input  logic           chain,
`endif
  output logic [3:0]     alu_op,
  output logic           alu_mode,
  output logic [W-1:0]   alu_x,
  output logic [W-1:0]   alu_y,
  output logic           alu_cin,
  input  logic [W-1:0]   alu_z,
  input  logic           alu_cout,
  output logic [2*W-1:0] result,
  output logic           c_out,
  output logic           zero,
  output logic           busy,
  output logic           done
);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;

  state_e         state_q, state_d;
  logic [3:0]     op_q, op_d;
  logic           mode_q, mode_d;
  logic           wide_q, wide_d;
  logic [2*W-1:0] a_q, a_d;
  logic [2*W-1:0] b_q, b_d;
  logic           cin_q, cin_d;
  logic           carry_q, carry_d;
  logic [2*W-1:0] result_q, result_d;
  logic           cout_q, cout_d;
  logic           zero_q, zero_d;
  logic           loCin;
  logic           isHi;
  logic           latchEn;

`ifdef ALU_SEQ_CHAIN_EN
  logic           chain_q, chain_d;
  // cout_q still holds the last completed operation's carry while LO is running
  assign loCin = chain_q ? cout_q : cin_q;
`else
  assign loCin = cin_q;
`endif

  assign latchEn = start && ((state_q == IDLE) || (state_q == DONE));
  assign isHi    = (state_q == HI);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    mode_d   = mode_q;
    wide_d   = wide_q;
    a_d      = a_q;
    b_d      = b_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_d  = chain_q;
    if (latchEn) chain_d = chain;
`endif
    if (latchEn) begin
      op_d   = op;
      mode_d = mode;
      wide_d = wide;
      a_d    = a;
      b_d    = b;
      cin_d  = c_in;
    end
    case (state_q)
      IDLE: begin
        if (start) state_d = LO;
      end
      LO: begin
        result_d[W-1:0] = alu_z;
        carry_d         = alu_cout;
        if (wide_q) begin
          state_d = HI;
        end else begin
          result_d[2*W-1:W] = '0;
          cout_d            = alu_cout;
          zero_d            = (alu_z == '0);
          state_d           = DONE;
        end
      end
      HI: begin
        result_d[2*W-1:W] = alu_z;
        cout_d            = alu_cout;
        zero_d            = (result_q[W-1:0] == '0) && (alu_z == '0);
        state_d           = DONE;
      end
      DONE: begin
        state_d = start ? LO : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= '0;
      mode_q   <= 1'b0;
      wide_q   <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q  <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      mode_q   <= mode_d;
      wide_q   <= wide_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q  <= chain_d;
`endif
    end
  end

  // Outside HI the ALU sees the low halves; its output is only consumed in LO and HI
  assign alu_op   = op_q;
  assign alu_mode = mode_q;
  assign alu_x    = isHi ? a_q[2*W-1:W] : a_q[W-1:0];
  assign alu_y    = isHi ? b_q[2*W-1:W] : b_q[W-1:0];
  assign alu_cin  = isHi ? carry_q : loCin;

  assign result = result_q;
  assign c_out  = cout_q;
  assign zero   = zero_q;
  assign busy   = (state_q == LO) || (state_q == HI);
  assign done   = (state_q == DONE);

endmodule
